shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_pkg.sv | 12 +
 rtl/shift_add_mult_if.sv | 14 +
 rtl/Sixteen_b_full_adder.sv | 20 ++
 rtl/shift_add_mult.sv | 63 ++++++
 tb/tb_shift_add_mult.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_pkg.sv
// shift_add_mult_pkg: shared state encoding and widths for the shift-add multiplier
package shift_add_mult_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  localparam int ITERS = 8;
  localparam int CNT_W = $clog2(ITERS);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand/product handshake bundle for the multiplier
interface shift_add_mult_if;
  import shift_add_mult_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [PROD_W-1:0] product;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/Sixteen_b_full_adder.sv
// Sixteen_b_full_adder: 16-bit ripple add/subtract, carry-out discarded
module Sixteen_b_full_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum
);
  logic [15:0] bx;
  logic c;
  assign bx = b ^ {16{sub}};
  // bit-serial carry ripple from LSB to MSB
  always_comb begin
    c = sub;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ bx[i] ^ c;
      c = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
  end
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: 8x8 unsigned sequential shift-and-add multiplier, fixed 8 iterations
module shift_add_mult
  import shift_add_mult_pkg::*;
(
  input  logic clk,
  input  logic rst,
  shift_add_mult_if.slave bus
);
  state_e state_q, state_d;
  logic [PROD_W-1:0] acc_q, acc_d, mcand_q, mcand_d, product_q, product_d, sum;
  logic [OP_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  Sixteen_b_full_adder u_add (.a(acc_q), .b(mcand_q), .sub(1'b0), .sum(sum));
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.product = product_q;
  // next-state and datapath: load on accept, shift/add while calculating, hold otherwise
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    product_d = product_q;
    if (state_q == IDLE && bus.in_valid) begin
      state_d = CALC;
      mcand_d = {{(PROD_W-OP_W){1'b0}}, bus.a};
      mplier_d = bus.b;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      acc_d = mplier_q[0] ? sum : acc_q;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(ITERS-1)) begin
        state_d = DONE;
        product_d = acc_d;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      product_q <= product_d;
    end
  end
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed table plus corner-case sequences for shift_add_mult
module tb_shift_add_mult;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  shift_add_mult_if bus ();
  shift_add_mult dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      tick();
      n++;
    end
    if (!bus.in_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic op(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n;
    wait_ready(nm);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    chk({nm, "_busy"}, bus.busy, 1);
    wait_done(nm, n);
    chk({nm, "_lat"}, n, 8);
    chk({nm, "_prod"}, bus.product, exp);
    tick();
  endtask

  initial begin
    int n;
    int last_acc;
    logic [7:0] sa, sb;
    vecs[0] = '{8'h00, 8'hFF, 16'h0000};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[3] = '{8'h01, 8'h01, 16'h0001};
    vecs[4] = '{8'h80, 8'h02, 16'h0100};
    vecs[5] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[6] = '{8'h10, 8'h10, 16'h0100};
    vecs[7] = '{8'hAA, 8'h55, 16'h3872};
    rst = 1;
    bus.in_valid = 0;
    bus.a = 0;
    bus.b = 0;
    bus.out_ready = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_product", bus.product, 0);
    for (int i = 0; i < 8; i++) op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

    bus.out_ready = 0;
    op("bp", 8'hFF, 8'hFF, 16'hFE01);
    bus.a = 8'h12;
    bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_prod", bus.product, 16'hFE01);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 1;
    tick();
    chk("bp_idle_ready", bus.in_ready, 1);
    chk("bp_idle_ovalid", bus.out_valid, 0);
    chk("bp_idle_prod", bus.product, 16'hFE01);
    tick();
    bus.in_valid = 0;
    chk("bp_accept_busy", bus.busy, 1);
    wait_done("bp2", n);
    chk("bp2_lat", n, 8);
    chk("bp2_prod", bus.product, 16'h11EE);
    tick();

    wait_ready("rst_mid");
    bus.a = 8'h0D;
    bus.b = 8'h0B;
    bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_ovalid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_prod", bus.product, 0);
    repeat (12) tick();
    chk("midrst_nodone", bus.out_valid, 0);
    op("post_rst", 8'h03, 8'h05, 16'h000F);

    bus.in_valid = 1;
    last_acc = 0;
    for (int i = 0; i < 16; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      bus.a = sa;
      bus.b = sb;
      wait_ready("stream");
      tick();
      if (i > 0) chk("stream_gap", cyc - last_acc, 10);
      last_acc = cyc;
      bus.a = ~sa;
      bus.b = ~sb;
      wait_done("stream", n);
      chk("stream_lat", n, 8);
      chk("stream_prod", bus.product, 32'(sa) * 32'(sb));
      tick();
    end
    bus.in_valid = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
